dot_matrix_scan: RTL and testbench
==================================

# dot_matrix_scan

Row-multiplexed scan driver for the 8x8 LED dot matrix. It consumes the eight `tetris` playfield rows `map0`..`map7` and drives one matrix row at a time with its column pattern. All eight rows are snapshotted at each frame start, so game updates never tear a displayed frame. It sits between the `tetris` core and the board's row/column pins.

## Interface

Parameters:
- `DWELL`, 4: cycles each row is lit; legal range 1..255.
- `BLANK`, 1: dark cycles after each row, used only when `DOTMATRIX_BLANK_EN` is defined; legal range 1..255.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `CLR`  in  1  asynchronous, active-low reset.
- `map0`..`map7`  in  8 each  playfield rows; row 0 is the top row; bit 7 is the leftmost column; 1 = pixel on.
- `row_sel`  out  8  one-hot row enable, active-high; bit i selects row i.
- `col_n`  out  8  column drive, active-low; equals `~shadow[row]` while a row is lit.
- `frame_start`  out  1  one-cycle pulse on the first lit cycle of row 0.
- `frame_cnt`  out  8  count of frames started; wraps from 255 to 0.

## Operation

- Shadow register: 8x8 bits. It is written only in LOAD, from all of `map0`..`map7` sampled at the same edge.
- The FSM has three states: LOAD, SHOW, BLK.
- LOAD lasts 1 cycle. The edge leaving LOAD does the following:
  - captures the shadow;
  - sets row index to 0;
  - drives `row_sel`=8'h01 and `col_n`=~`map0` (the value just sampled);
  - sets `frame_start`=1;
  - increments `frame_cnt`;
  - moves the FSM to SHOW.
- SHOW lasts `DWELL` cycles. `row_sel`=1<<row and `col_n`=~shadow[row] are held constant. `frame_start` is high only during the first SHOW cycle of row 0.
- At the end of SHOW:
  - With blanking enabled: go to BLK.
  - Otherwise, if row<7: row+1, stay in SHOW, and update outputs for the new row on the same edge.
  - Otherwise (row 7): go to LOAD.
- BLK lasts `BLANK` cycles, with `row_sel`=8'h00 and `col_n`=8'hFF. At its end: if row<7, row+1 and enter SHOW; if row 7, go to LOAD.
- LOAD cycle outputs are dark: `row_sel`=0, `col_n`=FF.
- Changes on `map*` outside the LOAD edge have no visible effect until the next frame.
- Exactly one bit of `row_sel` is high in SHOW. `row_sel` is never non-zero in LOAD or BLK.
- Row index is 3 bits and never wraps silently: row 7 always exits to LOAD.
- Dwell/blank counter is 8 bits. It is cleared on every state or row change.
- All outputs are registered; there is no combinational path from `map*` to any output.

## Timing

- Reset values while `CLR`=0, applied asynchronously:
  - `row_sel`=8'h00, `col_n`=8'hFF, `frame_start`=0, `frame_cnt`=8'h00;
  - FSM=LOAD, row=0, counter=0, shadow=0.
- First cycle after `CLR` rises is LOAD. Row 0 is lit from the following edge.
- Latency from the `map*` sample to visibility is 0 cycles after the LOAD edge.
- Frame period:
  - 1+8·DWELL cycles without blanking (33 at defaults);
  - 1+8·(DWELL+BLANK) with blanking (41 at defaults).
- `frame_start` pulses are exactly one frame period apart.
- Reset asserted mid-frame forces the reset values immediately. After release, the scan restarts from LOAD with `frame_cnt`=0.

## Configuration

- `DOTMATRIX_BLANK_EN`:
  - Defined: the BLK state exists, and `BLANK` dark cycles follow every row, including row 7 before LOAD. This suppresses ghosting.
  - Undefined: BLK and its counter logic are not compiled, `BLANK` is ignored, and rows switch back-to-back.

## Test plan

- Reset release with `map0`=8'hA5 and other rows 0, defaults, no blanking:
  - the cycle after LOAD gives `row_sel`=01, `col_n`=5A, `frame_start`=1, `frame_cnt`=1;
  - these values hold 4 cycles;
  - `frame_start` is 0 after the first cycle.
- Full frame with `mapN`=1<<N, no blanking:
  - `row_sel` steps 01,02,…,80, 4 cycles each;
  - `col_n`=~(1<<N);
  - next `frame_start` comes 33 cycles after the first.
- `DOTMATRIX_BLANK_EN` defined, defaults:
  - each 4-cycle row is followed by 1 cycle of `row_sel`=00, `col_n`=FF;
  - frame period is 41.
- Change `map3` from 00 to FF while row 1 is lit:
  - row 3 still shows `col_n`=FF in this frame;
  - the next frame shows `col_n`=00 on row 3.
- Run 256 frames: `frame_cnt` goes 255 then 0.
- Assert `CLR` low during row 5:
  - outputs go to reset values in the same cycle;
  - after release, 1 LOAD cycle, then row 0 is lit and `frame_cnt`=1.

Source files
------------

// File: rtl/dot_matrix_scan.sv
// Row-multiplexed scan driver for an 8x8 LED matrix; the frame is snapshotted at LOAD so it never tears.
// Define DOTMATRIX_BLANK_EN to insert BLANK dark cycles after every row (anti-ghosting).
module dot_matrix_scan #(
   parameter int DWELL = 4,
   parameter int BLANK = 1
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic [7:0] map0,
   input  logic [7:0] map1,
   input  logic [7:0] map2,
   input  logic [7:0] map3,
   input  logic [7:0] map4,
   input  logic [7:0] map5,
   input  logic [7:0] map6,
   input  logic [7:0] map7,
   output logic [7:0] row_sel,
   output logic [7:0] col_n,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
      $error("dot_matrix_scan: DWELL must be in 1..255");
   end
   if (BLANK < 1 || BLANK > 255) begin : g_bad_blank
      $error("dot_matrix_scan: BLANK must be in 1..255");
   end

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

`ifdef DOTMATRIX_BLANK_EN
   localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);
   typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_SHOW = 2'd1, ST_BLK = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_SHOW = 2'd1} state_t;
`endif

   state_t     r_state;
   logic [2:0] r_row;
   logic [7:0] r_cnt;
   logic [7:0] r_shadow [8];
   logic [7:0] r_row_sel;
   logic [7:0] r_col_n;
   logic       r_frame_start;
   logic [7:0] r_frame_cnt;

   state_t     w_state_next;
   logic [2:0] w_row_next;
   logic [7:0] w_cnt_next;
   logic [7:0] w_row_sel_next;
   logic [7:0] w_col_n_next;
   logic       w_frame_start_next;
   logic [7:0] w_frame_cnt_next;
   logic       w_load;
   logic [7:0] w_map [8];
   logic [2:0] w_row_inc;
   logic [7:0] w_row_inc_sel;

   assign w_map[0] = map0;
   assign w_map[1] = map1;
   assign w_map[2] = map2;
   assign w_map[3] = map3;
   assign w_map[4] = map4;
   assign w_map[5] = map5;
   assign w_map[6] = map6;
   assign w_map[7] = map7;

   assign w_row_inc     = r_row + 3'd1;
   assign w_row_inc_sel = 8'd1 << w_row_inc;

   always_comb begin
      w_state_next       = r_state;
      w_row_next         = r_row;
      w_cnt_next         = r_cnt + 8'd1;
      w_row_sel_next     = r_row_sel;
      w_col_n_next       = r_col_n;
      w_frame_start_next = 1'b0;
      w_frame_cnt_next   = r_frame_cnt;
      w_load             = 1'b0;
      case (r_state)
         ST_LOAD: begin
            // Row 0 is driven straight from the inputs being captured, so it is visible without delay.
            w_load             = 1'b1;
            w_state_next       = ST_SHOW;
            w_row_next         = 3'd0;
            w_cnt_next         = 8'd0;
            w_row_sel_next     = 8'h01;
            w_col_n_next       = ~w_map[0];
            w_frame_start_next = 1'b1;
            w_frame_cnt_next   = r_frame_cnt + 8'd1;
         end
         ST_SHOW: begin
            if (r_cnt == DWELL_LAST) begin
               w_cnt_next = 8'd0;
`ifdef DOTMATRIX_BLANK_EN
               w_state_next   = ST_BLK;
               w_row_sel_next = 8'h00;
               w_col_n_next   = 8'hFF;
`else
               if (r_row != 3'd7) begin
                  w_row_next     = w_row_inc;
                  w_row_sel_next = w_row_inc_sel;
                  w_col_n_next   = ~r_shadow[w_row_inc];
               end else begin
                  w_state_next   = ST_LOAD;
                  w_row_sel_next = 8'h00;
                  w_col_n_next   = 8'hFF;
               end
`endif
            end
         end
`ifdef DOTMATRIX_BLANK_EN
         ST_BLK: begin
            if (r_cnt == BLANK_LAST) begin
               w_cnt_next = 8'd0;
               if (r_row != 3'd7) begin
                  w_state_next   = ST_SHOW;
                  w_row_next     = w_row_inc;
                  w_row_sel_next = w_row_inc_sel;
                  w_col_n_next   = ~r_shadow[w_row_inc];
               end else begin
                  w_state_next = ST_LOAD;
               end
            end
         end
`endif
         default: begin
            w_state_next   = ST_LOAD;
            w_row_next     = 3'd0;
            w_cnt_next     = 8'd0;
            w_row_sel_next = 8'h00;
            w_col_n_next   = 8'hFF;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state       <= ST_LOAD;
         r_row         <= 3'd0;
         r_cnt         <= 8'd0;
         r_row_sel     <= 8'h00;
         r_col_n       <= 8'hFF;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            r_shadow[i] <= 8'h00;
         end
      end else begin
         r_state       <= w_state_next;
         r_row         <= w_row_next;
         r_cnt         <= w_cnt_next;
         r_row_sel     <= w_row_sel_next;
         r_col_n       <= w_col_n_next;
         r_frame_start <= w_frame_start_next;
         r_frame_cnt   <= w_frame_cnt_next;
         if (w_load) begin
            for (int i = 0; i < 8; i++) begin
               r_shadow[i] <= w_map[i];
            end
         end
      end
   end

   assign row_sel     = r_row_sel;
   assign col_n       = r_col_n;
   assign frame_start = r_frame_start;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Self-checking bench for dot_matrix_scan: outputs are predicted from the position inside the frame period.
// Honours DOTMATRIX_BLANK_EN the same way as the design.
module tb_dot_matrix_scan;

   localparam int D = 4;
`ifdef DOTMATRIX_BLANK_EN
   localparam int B = 1;
`else
   localparam int B = 0;
`endif
   localparam int SLOT = D + B;
   localparam int P    = 1 + 8 * SLOT;

   logic       CLK = 1'b0;
   logic       CLR = 1'b0;
   logic [7:0] map [8];
   logic [7:0] row_sel;
   logic [7:0] col_n;
   logic       frame_start;
   logic [7:0] frame_cnt;

   int         checks   = 0;
   int         failures = 0;
   int         t        = 0;
   logic [7:0] m_shadow [8];

   dot_matrix_scan #(.DWELL(D), .BLANK(1)) dut (
      .CLK(CLK), .CLR(CLR),
      .map0(map[0]), .map1(map[1]), .map2(map[2]), .map3(map[3]),
      .map4(map[4]), .map5(map[5]), .map6(map[6]), .map7(map[7]),
      .row_sel(row_sel), .col_n(col_n), .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s t=%0d observed=%02h expected=%02h", tag, t, obs, exp);
      end
   endtask

   // Reference: cycle 0 of each period is LOAD, then 8 slots of D lit + B dark cycles.
   task automatic check_outputs();
      int p, q, r, w;
      logic [7:0] e_sel, e_col, e_cnt;
      logic e_fs;
      p = t % P;
      e_sel = 8'h00; e_col = 8'hFF; e_fs = 1'b0;
      if (p != 0) begin
         q = p - 1;
         r = q / SLOT;
         w = q % SLOT;
         if (w < D) begin
            e_sel = 8'(1 << r);
            e_col = ~m_shadow[r];
            e_fs  = (r == 0 && w == 0);
         end
      end
      e_cnt = (t == 0) ? 8'h00 : 8'((t - 1) / P + 1);
      $display("cycle t=%0d row_sel=%02h col_n=%02h fs=%0b cnt=%0d", t, row_sel, col_n, frame_start, frame_cnt);
      chk("row_sel", row_sel, e_sel);
      chk("col_n", col_n, e_col);
      chk("frame_start", {7'd0, frame_start}, {7'd0, e_fs});
      chk("frame_cnt", frame_cnt, e_cnt);
   endtask

   // Called at a falling edge; checks, optionally perturbs maps, records the LOAD snapshot.
   task automatic run_cycles(input int n, input bit rnd);
      for (int k = 0; k < n; k++) begin
         check_outputs();
         if (rnd && $urandom_range(0, 2) == 0) map[$urandom_range(0, 7)] = 8'($urandom);
         if (t % P == 0) begin
            for (int i = 0; i < 8; i++) m_shadow[i] = map[i];
         end
         @(negedge CLK);
         t++;
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_row_sel"}, row_sel, 8'h00);
      chk({tag, "_col_n"}, col_n, 8'hFF);
      chk({tag, "_fs"}, {7'd0, frame_start}, 8'h00);
      chk({tag, "_cnt"}, frame_cnt, 8'h00);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         map[i] = 8'h00;
         m_shadow[i] = 8'h00;
      end
      repeat (3) @(negedge CLK);
      check_reset("rst");

      // First frame: map0 = A5 only.
      map[0] = 8'hA5;
      CLR = 1'b1;
      t = 0;
      run_cycles(P, 1'b0);

      // Diagonal pattern, two frames.
      for (int i = 0; i < 8; i++) map[i] = 8'(1 << i);
      run_cycles(2 * P, 1'b0);

      // Mid-frame change of map3 while row 1 is lit must not tear the current frame.
      for (int i = 0; i < 8; i++) map[i] = 8'h00;
      run_cycles(2 + SLOT, 1'b0);
      map[3] = 8'hFF;
      run_cycles(2 * P, 1'b0);

      // Randomised maps long enough for frame_cnt to wrap.
      run_cycles(260 * P, 1'b1);

      // Asynchronous reset during row 5.
      while (!((t % P) >= 1 && ((t % P) - 1) / SLOT == 5)) run_cycles(1, 1'b1);
      #1 CLR = 1'b0;
      #1 check_reset("midrst");
      @(negedge CLK);
      check_reset("midrst_hold");
      @(negedge CLK);
      CLR = 1'b1;
      t = 0;
      run_cycles(2 * P, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
